// File: rtl/m107_sdr_pkg.sv
// Shared SDRAM-side definitions for the GA21 object DMA read channels.
`timescale 1ns/1ps
package m107_sdr_pkg;
  localparam int SDR_BURST_LEN      = 4;
  localparam int SPRITE_ENTRY_BYTES = 8;
  localparam int BEAT_W             = $clog2(SDR_BURST_LEN);
  localparam logic [24:0] REGION_SPRITE_TABLE = 25'h010_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, BURST, DRAIN} fetch_state_t;
endpackage

// File: rtl/sdr_beat_collector.sv
// Counts 16-bit SDRAM beats and shifts them into a 64-bit line; discard mode only counts.
`timescale 1ns/1ps
module sdr_beat_collector
  import m107_sdr_pkg::*;
(
  input  logic        clk_ram,
  input  logic        reset,
  input  logic        en,
  input  logic        discard,
  input  logic        beat_valid,
  input  logic [15:0] beat_data,
  output logic        last,
  output logic [63:0] line
);
  logic [BEAT_W-1:0] beat_cnt;
  logic [47:0]       shift;
  logic              take;

  assign take = en & beat_valid;
  assign last = take && (beat_cnt == BEAT_W'(SDR_BURST_LEN - 1));
  // Final word comes straight from the bus so the line is ready in the last-beat cycle.
  assign line = {beat_data, shift};

  always_ff @(posedge clk_ram) begin
    if (reset) begin
      beat_cnt <= '0;
      shift    <= '0;
    end else if (take) begin
      beat_cnt <= beat_cnt + 1'b1;
      if (!discard) shift <= {beat_data, shift[47:16]};
    end
  end
endmodule

// File: rtl/sprite_table_fetch.sv
// Sprite-instance-table read responder: 64-bit entry fetch as a 4-beat SDRAM burst,
// with a single-entry last-line cache and supersede handling for overlapping requests.
`timescale 1ns/1ps
module sprite_table_fetch
  import m107_sdr_pkg::*;
#(
  parameter int ADDR_W   = 25,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic              clk_ram,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic [63:0]       data,
  output logic              rdy,
  input  logic              cache_flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_valid,
  input  logic [15:0]       mem_data
);
  localparam int TAG_W = ADDR_W - 3;

  fetch_state_t      state, state_nxt;
  logic              req_d, req_edge, hit, last, fill;
  logic [TAG_W-1:0]  req_tag, pend_tag, pend_tag_nxt, c_tag;
  logic              pend, pend_nxt, c_valid;
  logic [63:0]       c_line, line, data_nxt;
  logic              rdy_nxt, mem_req_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic              unused_low;

  assign unused_low = ^addr[2:0];
  assign req_tag    = addr[ADDR_W-1:3];
  assign req_edge   = req & ~req_d;
  assign hit        = CACHE_EN && c_valid && (c_tag == req_tag);

  sdr_beat_collector u_col (
    .clk_ram    (clk_ram),
    .reset      (reset),
    .en         (state == BURST || state == DRAIN),
    .discard    (state == DRAIN),
    .beat_valid (mem_valid),
    .beat_data  (mem_data),
    .last       (last),
    .line       (line)
  );

  always_ff @(posedge clk_ram) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (req_edge && !hit) state_nxt = ISSUE;
      // An edge landing with the ack means the old burst is already committed.
      ISSUE: if (mem_ack) state_nxt = req_edge ? DRAIN : BURST;
      BURST: if (req_edge)  state_nxt = last ? ISSUE : DRAIN;
             else if (last) state_nxt = IDLE;
      DRAIN: if (last) state_nxt = ISSUE;
    endcase
  end

  always_comb begin
    rdy_nxt      = 1'b0;
    data_nxt     = data;
    mem_req_nxt  = mem_req;
    mem_addr_nxt = mem_addr;
    pend_nxt     = pend;
    pend_tag_nxt = pend_tag;
    fill         = 1'b0;
    unique case (state)
      IDLE: if (req_edge) begin
        if (hit) begin
          rdy_nxt  = 1'b1;
          data_nxt = c_line;
        end else begin
          mem_req_nxt  = 1'b1;
          mem_addr_nxt = {req_tag, 3'b000};
        end
      end
      ISSUE: if (mem_ack) begin
        mem_req_nxt = 1'b0;
        if (req_edge) begin
          pend_nxt     = 1'b1;
          pend_tag_nxt = req_tag;
        end
      end else if (req_edge) begin
        mem_addr_nxt = {req_tag, 3'b000};
      end
      BURST: if (req_edge) begin
        if (last) begin
          mem_req_nxt  = 1'b1;
          mem_addr_nxt = {req_tag, 3'b000};
        end else begin
          pend_nxt     = 1'b1;
          pend_tag_nxt = req_tag;
        end
      end else if (last) begin
        rdy_nxt  = 1'b1;
        data_nxt = line;
        fill     = 1'b1;
      end
      DRAIN: if (last) begin
        mem_req_nxt  = 1'b1;
        mem_addr_nxt = {req_edge ? req_tag : pend_tag, 3'b000};
        pend_nxt     = 1'b0;
      end else if (req_edge) begin
        pend_tag_nxt = req_tag;
      end
    endcase
  end

  always_ff @(posedge clk_ram) begin
    if (reset) begin
      req_d    <= 1'b0;
      rdy      <= 1'b0;
      data     <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      pend     <= 1'b0;
      pend_tag <= '0;
    end else begin
      req_d    <= req;
      rdy      <= rdy_nxt;
      data     <= data_nxt;
      mem_req  <= mem_req_nxt;
      mem_addr <= mem_addr_nxt;
      pend     <= pend_nxt;
      pend_tag <= pend_tag_nxt;
    end
  end

  // Flush has priority over a fill landing in the same cycle.
  always_ff @(posedge clk_ram) begin
    if (reset) begin
      c_valid <= 1'b0;
      c_tag   <= '0;
      c_line  <= '0;
    end else begin
      if (fill) begin
        c_tag  <= mem_addr[ADDR_W-1:3];
        c_line <= line;
      end
      if (cache_flush)          c_valid <= 1'b0;
      else if (fill && CACHE_EN) c_valid <= 1'b1;
    end
  end
endmodule
